// File: rtl/keypad_matrix_scanner.sv
// NROWxNCOL matrix keypad scanner with per-key debounce,
// a first-word-fall-through press/release event FIFO, overflow flag and IRQ.
module keypad_matrix_scanner #(
    parameter int NROW       = 4,
    parameter int NCOL       = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic [NROW-1:0]               iROW,
    output logic [NCOL-1:0]               oCOL,
    output logic [NROW*NCOL-1:0]          oKEYST,
    output logic [8:0]                    oEVT_DATA,
    output logic                          oEVT_VALID,
    input  logic                          iEVT_READY,
    output logic [$clog2(FIFO_DEPTH):0]   oEVT_COUNT,
    output logic                          oOVF,
    input  logic                          iOVF_CLR,
    input  logic                          iIRQ_EN,
    output logic                          oIRQ
);

    localparam int NK       = NROW * NCOL;
    localparam int KW       = (NK > 1) ? $clog2(NK) : 1;
    localparam int RW       = (NROW > 1) ? $clog2(NROW) : 1;
    localparam int CW       = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int DW       = $clog2(SCAN_DIV);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int DRV_LAST = (SCAN_DIV > NROW + 2) ? SCAN_DIV - NROW - 3 : 0;

    typedef enum logic [1:0] {DRIVE, SAMPLE, EMIT, NEXT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            run;
    logic [DW-1:0]   div;
    logic [CW-1:0]   col;
    logic [CW-1:0]   col_nxt;
    logic [RW-1:0]   row;
    logic [NROW-1:0] raw;
    logic [3:0]      cnt [NK];
    logic            do_sample;
    logic            do_emit;
    logic            do_next;

    logic [KW-1:0]   kidx;
    logic            raw_bit;
    logic            st_bit;
    logic            hit;
    logic            push;
    logic [8:0]      evt;

    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic            pop;
    logic            full;
    logic            accept;
    logic            drop;

    // run holds the FSM for the reset-exit cycle so column 0 gets a full period
    always_ff @(posedge iCLK) begin
        if (iRST)
            state <= DRIVE;
        else if (run)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DRIVE:  if (div == DW'(DRV_LAST)) state_nxt = SAMPLE;
            SAMPLE: state_nxt = EMIT;
            EMIT:   if (row == RW'(NROW - 1)) state_nxt = NEXT;
            NEXT:   state_nxt = DRIVE;
            default: state_nxt = DRIVE;
        endcase
    end

    always_comb begin
        do_sample = run && (state == SAMPLE);
        do_emit   = run && (state == EMIT);
        do_next   = run && (state == NEXT);
    end

    always_comb begin
        col_nxt = col;
        if (do_next)
            col_nxt = (col == CW'(NCOL - 1)) ? '0 : col + 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            run  <= 1'b0;
            div  <= '0;
            col  <= '0;
            row  <= '0;
            raw  <= '0;
            oCOL <= '1;
        end else begin
            run  <= 1'b1;
            col  <= col_nxt;
            oCOL <= ~(NCOL'(1) << col_nxt);
            if (do_next)
                div <= '0;
            else if (run)
                div <= div + 1'b1;
            if (do_sample) begin
                raw <= ~iROW;
                row <= '0;
            end else if (do_emit) begin
                row <= (row == RW'(NROW - 1)) ? '0 : row + 1'b1;
            end
        end
    end

    always_comb begin
        kidx    = KW'(int'(row) * NCOL + int'(col));
        raw_bit = raw[row];
        st_bit  = oKEYST[kidx];
        hit     = ({1'b0, cnt[kidx]} + 5'd1) >= 5'(DEBOUNCE);
        push    = do_emit && (raw_bit != st_bit) && hit;
        evt     = {raw_bit, 8'(kidx)};
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int k = 0; k < NK; k++)
                cnt[k] <= '0;
            oKEYST <= '0;
        end else if (do_emit) begin
            if (raw_bit == st_bit) begin
                cnt[kidx] <= '0;
            end else if (!hit) begin
                cnt[kidx] <= cnt[kidx] + 1'b1;
            end else begin
                oKEYST[kidx] <= raw_bit;
                cnt[kidx]    <= '0;
            end
        end
    end

    // a full FIFO only takes a new event when the head leaves in the same cycle
    always_comb begin
        pop    = oEVT_VALID && iEVT_READY;
        full   = oEVT_COUNT == (AW + 1)'(FIFO_DEPTH);
        accept = push && (!full || pop);
        drop   = push && full && !pop;
    end

    always_ff @(posedge iCLK) begin
        if (accept)
            mem[wp] <= evt;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            wp         <= '0;
            rp         <= '0;
            oEVT_COUNT <= '0;
            oOVF       <= 1'b0;
        end else begin
            if (accept)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (accept && !pop)
                oEVT_COUNT <= oEVT_COUNT + 1'b1;
            else if (pop && !accept)
                oEVT_COUNT <= oEVT_COUNT - 1'b1;
            if (drop)
                oOVF <= 1'b1;
            else if (iOVF_CLR)
                oOVF <= 1'b0;
        end
    end

    assign oEVT_VALID = oEVT_COUNT != '0;
    assign oEVT_DATA  = oEVT_VALID ? mem[rp] : '0;
    assign oIRQ       = iIRQ_EN && oEVT_VALID;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: keypad model, event scoreboard,
// table of press/release vectors plus hand-written corner sequences.
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col;
    logic [15:0] keyst;
    logic [8:0]  evt_data;
    logic        evt_valid;
    logic        evt_ready;
    logic [2:0]  evt_count;
    logic        ovf;
    logic        ovf_clr;
    logic        irq_en;
    logic        irq;

    logic [15:0] keys;
    logic [3:0]  col_neg;
    logic [8:0]  q[$];
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[6];
    logic [15:0] prev_exp;
    int          cnt_tr[64];
    logic [8:0]  dat_tr[64];
    int          n;
    int          f;

    keypad_matrix_scanner #(
        .NROW(4), .NCOL(4), .SCAN_DIV(8), .DEBOUNCE(2), .FIFO_DEPTH(4)
    ) dut (
        .iCLK(clk), .iRST(rst), .iROW(row_in), .oCOL(col),
        .oKEYST(keyst), .oEVT_DATA(evt_data), .oEVT_VALID(evt_valid),
        .iEVT_READY(evt_ready), .oEVT_COUNT(evt_count), .oOVF(ovf),
        .iOVF_CLR(ovf_clr), .iIRQ_EN(irq_en), .oIRQ(irq)
    );

    always #5 clk = ~clk;

    // keypad: a closed key pulls its row low while its column is driven low
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c])
                    row_in[r] = 1'b0;
    end

    always @(negedge clk) col_neg <= col;

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && evt_ready && evt_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL evt_unexpected: got %h, none expected", evt_data);
            end else begin
                e = q.pop_front();
                if (evt_data !== e) begin
                    errors++;
                    $display("FAIL evt_data: got %h expected %h", evt_data, e);
                end
            end
            checks++;
            if (irq !== irq_en) begin
                errors++;
                $display("FAIL irq: got %b expected %b", irq, irq_en);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait for the tick just after column 0 starts being driven
    task automatic align();
        int i;
        i = 0;
        while (!(col == 4'b1110 && col_neg != 4'b1110) && i < 40) begin
            tick();
            i++;
        end
        checks++;
        if (i >= 40) begin
            errors++;
            $display("FAIL align: col=%b never restarted at column 0", col);
        end
    endtask

    task automatic push_diff(input logic [15:0] from, input logic [15:0] to);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (from[r*4+c] != to[r*4+c])
                    q.push_back({to[r*4+c], 8'(r*4+c)});
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
        irq_en = 1'b1; keys = '0;
        tbl[0] = '{16'h0040, 2, 16'h0040};
        tbl[1] = '{16'h0000, 2, 16'h0000};
        tbl[2] = '{16'h0040, 1, 16'h0000};
        tbl[3] = '{16'h0000, 2, 16'h0000};
        tbl[4] = '{16'h8421, 2, 16'h8421};
        tbl[5] = '{16'h0000, 2, 16'h0000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_col", 32'(col), 32'hF);
        chk("rst_keyst", 32'(keyst), 0);
        chk("rst_count", 32'(evt_count), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_data", 32'(evt_data), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_irq", 32'(irq), 0);

        rst = 1'b0;
        tick();
        chk("col0_first", 32'(col), 32'hE);
        n = 0;
        while (col == 4'b1110 && n < 20) begin
            tick();
            n++;
        end
        chk("col_period", 32'(n), 8);
        chk("col1", 32'(col), 32'hD);

        evt_ready = 1'b1;
        prev_exp = '0;
        for (int i = 0; i < 6; i++) begin
            align();
            keys = tbl[i].keys;
            push_diff(prev_exp, tbl[i].exp);
            repeat (tbl[i].frames * 32) tick();
            chk($sformatf("tbl%0d_keyst", i), 32'(keyst), 32'(tbl[i].exp));
            chk($sformatf("tbl%0d_drained", i), 32'(q.size()), 0);
            prev_exp = tbl[i].exp;
        end

        // two keys in one column, nothing popped
        evt_ready = 1'b0;
        align();
        keys = 16'h2002;
        q.push_back(9'h101);
        q.push_back(9'h10D);
        for (int i = 0; i < 64; i++) begin
            tick();
            cnt_tr[i] = int'(evt_count);
            dat_tr[i] = evt_data;
        end
        f = -1;
        for (int i = 63; i >= 0; i--)
            if (cnt_tr[i] == 1) f = i;
        chk("pair_seen", 32'(f >= 0 && f <= 60), 1);
        if (f >= 0 && f <= 60) begin
            chk("pair_first", 32'(dat_tr[f]), 32'h101);
            chk("pair_gap", 32'(cnt_tr[f+2]), 1);
            chk("pair_second", 32'(cnt_tr[f+3]), 2);
        end
        chk("pair_count", 32'(evt_count), 2);
        irq_en = 1'b0;
        #1;
        chk("irq_masked", 32'(irq), 0);
        irq_en = 1'b1;
        #1;
        chk("irq_on", 32'(irq), 1);
        evt_ready = 1'b1;
        align();
        keys = 16'h0000;
        q.push_back(9'h001);
        q.push_back(9'h00D);
        repeat (64) tick();
        chk("pair_drained", 32'(q.size()), 0);
        chk("pair_keyst", 32'(keyst), 0);

        // five events into a four-deep FIFO
        evt_ready = 1'b0;
        align();
        keys = 16'h001F;
        q.push_back(9'h100);
        q.push_back(9'h104);
        q.push_back(9'h101);
        q.push_back(9'h102);
        repeat (64) tick();
        chk("ovf_count", 32'(evt_count), 4);
        chk("ovf_flag", 32'(ovf), 1);
        chk("ovf_keyst", 32'(keyst), 32'h1F);
        chk("ovf_head", 32'(evt_data), 32'h100);
        align();
        keys = 16'h001E;
        repeat (35) tick();
        evt_ready = 1'b1;
        q.push_back(9'h000);
        tick();
        evt_ready = 1'b0;
        chk("pushpop_count", 32'(evt_count), 4);
        chk("pushpop_keyst", 32'(keyst), 32'h1E);
        chk("ovf_sticky", 32'(ovf), 1);
        repeat (28) tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 0);
        evt_ready = 1'b1;
        align();
        keys = 16'h0000;
        q.push_back(9'h004);
        q.push_back(9'h001);
        q.push_back(9'h002);
        q.push_back(9'h003);
        repeat (64) tick();
        chk("ovf_drained", 32'(q.size()), 0);
        chk("ovf_empty", 32'(evt_count), 0);

        // reset mid-EMIT with events queued
        evt_ready = 1'b0;
        align();
        keys = 16'h0007;
        repeat (64) tick();
        chk("mid_count", 32'(evt_count), 3);
        align();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_count", 32'(evt_count), 0);
        chk("mid_rst_keyst", 32'(keyst), 0);
        chk("mid_rst_valid", 32'(evt_valid), 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        q.push_back(9'h100);
        q.push_back(9'h101);
        q.push_back(9'h102);
        repeat (80) tick();
        chk("rereport_keyst", 32'(keyst), 32'h7);
        chk("rereport_drained", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
